needs_meter: RTL and testbench

Needs-state keeper for the Tamagotchi pet. It holds the three 0..5 need levels (hunger, energy, entertainment) that the central FSM and the LCD controller consume. Levels decay on a one-second time base and are replenished by the debounced feed/play pulses and the sleep state. Test mode speeds up the time base so a demo can walk through every face quickly.

---
 rtl/needs_pkg.sv | 22 ++
 rtl/needs_meter_if.sv | 24 ++
 rtl/needs_meter_tick_gen.sv | 46 ++++
 rtl/needs_meter.sv | 90 +++++++++
 tb/tb_needs_meter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/needs_pkg.sv
// Shared widths, limits and helpers for the pet needs meter.
package needs_pkg;
    localparam int LVL_W   = 3;
    localparam int MAX_LVL = 5;

    typedef logic [LVL_W-1:0] lvl_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturate a signed intermediate level into the legal 0..MAX_LVL range.
    function automatic lvl_t clamp(input logic signed [3:0] v);
        if (v < 0)
            return '0;
        else if (v > MAX_LVL)
            return lvl_t'(MAX_LVL);
        else
            return v[LVL_W-1:0];
    endfunction
endpackage

// File: rtl/needs_meter_if.sv
// Pulse/level inputs and need-level outputs of the needs meter.
interface needs_meter_if;
    import needs_pkg::*;

    logic feed_p;
    logic play_p;
    logic sleeping;
    logic test_mode;
    lvl_t hunger;
    lvl_t energy;
    lvl_t entertainment;
    logic critical;
    logic tick;

    modport master (
        output feed_p, play_p, sleeping, test_mode,
        input  hunger, energy, entertainment, critical, tick
    );

    modport slave (
        input  feed_p, play_p, sleeping, test_mode,
        output hunger, energy, entertainment, critical, tick
    );
endinterface

// File: rtl/needs_meter_tick_gen.sv
// Time-base divider; a test_mode change restarts the count so the first
// tick in the new mode arrives a full new period later.
module tick_gen
    import needs_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int TEST_DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic test_mode,
    output logic tick
);
    localparam int MAXD = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
    localparam int CW   = cnt_w(MAXD);

    logic [CW-1:0] tcnt;
    logic [CW-1:0] div_m1;
    logic          mode_q;
    logic          chg;
    logic          wrap;

    assign div_m1 = test_mode ? CW'(TEST_DIV - 1) : CW'(TICK_DIV - 1);
    assign chg    = test_mode ^ mode_q;
    assign wrap   = (tcnt == div_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt   <= '0;
            mode_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            mode_q <= test_mode;
            if (chg) begin
                tcnt <= '0;
                tick <= 1'b0;
            end else if (wrap) begin
                tcnt <= '0;
                tick <= 1'b1;
            end else begin
                tcnt <= tcnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/needs_meter.sv
// Hunger/energy/entertainment levels: decay on period counters driven by
// the time base, replenished by feed/play pulses and by sleeping.
module needs_meter
    import needs_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int TEST_DIV   = 50_000,
    parameter int HUNGER_PER = 10,
    parameter int ENERGY_PER = 15,
    parameter int JOY_PER    = 8
) (
    input logic          clk,
    input logic          rst,
    needs_meter_if.slave bus
);
    localparam int HW = cnt_w(HUNGER_PER);
    localparam int EW = cnt_w(ENERGY_PER);
    localparam int JW = cnt_w(JOY_PER);

    logic          tick;
    logic [HW-1:0] hcnt;
    logic [EW-1:0] ecnt;
    logic [JW-1:0] jcnt;
    logic          h_ev, e_ev, j_ev;
    logic          feed_ok, play_ok;
    logic signed [3:0] h_d, e_d, j_d;
    lvl_t          hunger_q, energy_q, joy_q;
    logic          critical_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TEST_DIV (TEST_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .test_mode (bus.test_mode),
        .tick      (tick)
    );

    assign h_ev    = tick && (hcnt == HW'(HUNGER_PER - 1));
    assign e_ev    = tick && (ecnt == EW'(ENERGY_PER - 1));
    assign j_ev    = tick && (jcnt == JW'(JOY_PER - 1));
    assign feed_ok = bus.feed_p & ~bus.sleeping;
    assign play_ok = bus.play_p & ~bus.sleeping;

    // Signed deltas; a coincident pulse and event cancel before clamping.
    always_comb begin
        h_d = 4'sd0;
        e_d = 4'sd0;
        j_d = 4'sd0;
        if (feed_ok) h_d = h_d + 4'sd1;
        if (h_ev)    h_d = h_d - 4'sd1;
        if (play_ok) j_d = j_d + 4'sd1;
        if (j_ev)    j_d = j_d - 4'sd1;
        if (e_ev)    e_d = bus.sleeping ? 4'sd1 : -4'sd1;
        if (play_ok) e_d = e_d - 4'sd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            ecnt <= '0;
            jcnt <= '0;
        end else if (tick) begin
            hcnt <= h_ev ? '0 : hcnt + 1'b1;
            ecnt <= e_ev ? '0 : ecnt + 1'b1;
            jcnt <= j_ev ? '0 : jcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hunger_q   <= lvl_t'(MAX_LVL);
            energy_q   <= lvl_t'(MAX_LVL);
            joy_q      <= lvl_t'(MAX_LVL);
            critical_q <= 1'b0;
        end else begin
            hunger_q   <= clamp($signed({1'b0, hunger_q}) + h_d);
            energy_q   <= clamp($signed({1'b0, energy_q}) + e_d);
            joy_q      <= clamp($signed({1'b0, joy_q}) + j_d);
            critical_q <= (hunger_q == '0) | (energy_q == '0) | (joy_q == '0);
        end
    end

    assign bus.hunger        = hunger_q;
    assign bus.energy        = energy_q;
    assign bus.entertainment = joy_q;
    assign bus.critical      = critical_q;
    assign bus.tick          = tick;
endmodule

// File: tb/tb_needs_meter.sv
// Directed bench for needs_meter with a short time base and short periods.
module tb_needs_meter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    needs_meter_if bus();

    needs_meter #(
        .TICK_DIV   (4),
        .TEST_DIV   (2),
        .HUNGER_PER (2),
        .ENERGY_PER (3),
        .JOY_PER    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       feed;
        logic       play;
        logic [2:0] h;
        logic [2:0] e;
        logic [2:0] j;
        logic       crit;
        logic       tick;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [2:0] h, input logic [2:0] e,
                       input logic [2:0] j, input logic c, input logic t);
        tests++;
        if ({bus.hunger, bus.energy, bus.entertainment, bus.critical, bus.tick} !== {h, e, j, c, t}) begin
            fails++;
            $display("FAIL %s: got h=%0d e=%0d j=%0d crit=%0b tick=%0b, expected h=%0d e=%0d j=%0d crit=%0b tick=%0b",
                     nm, bus.hunger, bus.energy, bus.entertainment, bus.critical, bus.tick, h, e, j, c, t);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this returns, the next rising edge is edge 1 after release.
    task automatic do_reset();
        bus.feed_p    = 1'b0;
        bus.play_p    = 1'b0;
        bus.sleeping  = 1'b0;
        bus.test_mode = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_state", 3'd5, 3'd5, 3'd5, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;

        // Idle time base, then a play and a feed pulse.
        vecs[0]  = '{0, 0, 5, 5, 5, 0, 0};
        vecs[1]  = '{0, 0, 5, 5, 5, 0, 0};
        vecs[2]  = '{0, 0, 5, 5, 5, 0, 0};
        vecs[3]  = '{0, 0, 5, 5, 5, 0, 1};
        vecs[4]  = '{0, 0, 5, 5, 5, 0, 0};
        vecs[5]  = '{0, 0, 5, 5, 5, 0, 0};
        vecs[6]  = '{0, 0, 5, 5, 5, 0, 0};
        vecs[7]  = '{0, 0, 5, 5, 5, 0, 1};
        vecs[8]  = '{0, 0, 4, 5, 4, 0, 0};
        vecs[9]  = '{0, 0, 4, 5, 4, 0, 0};
        vecs[10] = '{0, 1, 4, 4, 5, 0, 0};
        vecs[11] = '{1, 0, 5, 4, 5, 0, 1};
        vecs[12] = '{0, 0, 5, 3, 5, 0, 0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            bus.feed_p = vecs[i].feed;
            bus.play_p = vecs[i].play;
            step(1);
            chk($sformatf("vec%0d", i), vecs[i].h, vecs[i].e, vecs[i].j, vecs[i].crit, vecs[i].tick);
        end
        bus.feed_p = 1'b0;
        bus.play_p = 1'b0;

        // Starve: hunger floors at 0, critical follows one cycle later.
        do_reset();
        step(41);
        chk("starve_h0", 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);
        step(1);
        chk("starve_crit", 3'd0, 3'd2, 3'd0, 1'b1, 1'b0);
        step(7);
        chk("starve_hold", 3'd0, 3'd1, 3'd0, 1'b1, 1'b0);

        // Feed coincident with a hunger decay event at hunger=3.
        do_reset();
        step(24);
        chk("feed_pre", 3'd3, 3'd4, 3'd3, 1'b0, 1'b1);
        bus.feed_p = 1'b1;
        step(1);
        chk("feed_vs_decay", 3'd3, 3'd3, 3'd2, 1'b0, 1'b0);
        step(1);
        bus.feed_p = 1'b0;
        chk("feed_alone", 3'd4, 3'd3, 3'd2, 1'b0, 1'b0);
        step(7);
        chk("feed_then_decay", 3'd3, 3'd3, 3'd1, 1'b0, 1'b0);

        // Play on an awake energy event at energy=1.
        do_reset();
        step(60);
        chk("play_pre", 3'd0, 3'd1, 3'd0, 1'b1, 1'b1);
        bus.play_p = 1'b1;
        step(1);
        bus.play_p = 1'b0;
        chk("play_floor", 3'd0, 3'd0, 3'd1, 1'b1, 1'b0);

        // Sleeping from energy=2 with feeds that must be ignored.
        do_reset();
        step(37);
        chk("sleep_pre", 3'd1, 3'd2, 3'd1, 1'b0, 1'b0);
        bus.sleeping = 1'b1;
        step(1);
        bus.feed_p = 1'b1;
        step(1);
        bus.feed_p = 1'b0;
        chk("sleep_feed_ign", 3'd1, 3'd2, 3'd1, 1'b0, 1'b0);
        step(2);
        chk("sleep_h_decay", 3'd0, 3'd2, 3'd0, 1'b0, 1'b0);
        step(3);
        bus.feed_p = 1'b1;
        step(1);
        bus.feed_p = 1'b0;
        chk("sleep_feed_ign2", 3'd0, 3'd2, 3'd0, 1'b1, 1'b0);
        step(4);
        chk("sleep_e_up1", 3'd0, 3'd3, 3'd0, 1'b1, 1'b0);
        step(12);
        chk("sleep_e_up2", 3'd0, 3'd4, 3'd0, 1'b1, 1'b0);
        bus.sleeping = 1'b0;

        // test_mode change mid-count, then asynchronous reset mid-period.
        do_reset();
        step(2);
        bus.test_mode = 1'b1;
        bus.play_p    = 1'b1;
        step(1);
        bus.play_p = 1'b0;
        chk("tm_clear", 3'd5, 3'd4, 3'd5, 1'b0, 1'b0);
        step(1);
        chk("tm_t4", 3'd5, 3'd4, 3'd5, 1'b0, 1'b0);
        step(1);
        chk("tm_t5", 3'd5, 3'd4, 3'd5, 1'b0, 1'b1);
        step(1);
        chk("tm_t6", 3'd5, 3'd4, 3'd5, 1'b0, 1'b0);
        step(1);
        chk("tm_t7", 3'd5, 3'd4, 3'd5, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 3'd5, 3'd5, 3'd5, 1'b0, 1'b0);
        bus.test_mode = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);
        chk("post_rst_t3", 3'd5, 3'd5, 3'd5, 1'b0, 1'b0);
        step(1);
        chk("post_rst_t4", 3'd5, 3'd5, 3'd5, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
